sega_joy_reader: RTL and testbench

- Polls two DB9 joystick ports using the Sega select-line (pin 7) protocol, with 3-button and 6-button Megadrive detection and Master System fallback.
- Produces two 12-bit active-low button words in the format MXYZ SACB RLDU.
- Sits directly upstream of the core's control mapping (m_up/m_down/m_left/m_right/m_fire, coin/start) in the Multicore/Unamiga top level, and drives joyX_p7_o.
- Replaces the legacy polling scheme clocked from the negative edge of hsync with a single-clock design that uses an internal step strobe.

---
 rtl/sega_joy_reader_if.sv | 22 ++
 rtl/sega_joy_reader.sv | 134 +++++++++++++
 tb/tb_sega_joy_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sega_joy_reader_if.sv
// Board-side bundle for the two DB9 joystick ports: raw pins in, select line
// and decoded active-low button words out.
interface sega_joy_reader_if;
  logic [5:0]  joy1_pins_i;
  logic [5:0]  joy2_pins_i;
  logic        p7_o;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        six1_o;
  logic        six2_o;
  logic        frame_o;

  modport slave (
    input  joy1_pins_i, joy2_pins_i,
    output p7_o, joy1_o, joy2_o, six1_o, six2_o, frame_o
  );

  modport master (
    output joy1_pins_i, joy2_pins_i,
    input  p7_o, joy1_o, joy2_o, six1_o, six2_o, frame_o
  );
endinterface

// File: rtl/sega_joy_reader.sv
// Sega select-line poller for two DB9 ports: 3/6-button Megadrive detection
// with Master System fallback, single clock with an internal step strobe.
module sega_joy_port (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  pins_i,
  input  logic        step_en_i,
  input  logic [7:0]  step_i,
  output logic [11:0] joy_o,
  output logic        six_o
);
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [11:0] shadow_q, shadow_d;
  logic        six_q, six_d;
  logic [11:0] joy_q, joy_d;
  logic        six_out_q, six_out_d;

  always_comb begin
    sync1_d   = pins_i;
    sync2_d   = sync1_q;
    shadow_d  = shadow_q;
    six_d     = six_q;
    joy_d     = joy_q;
    six_out_d = six_out_q;
    // sync2_q = {p9,p6,R,L,D,U}; the meaning depends on the current p7 phase
    if (step_en_i) begin
      case (step_i)
        8'd2: begin
          shadow_d[5:0] = sync2_q;
          six_d         = 1'b0;
        end
        8'd3: begin
          if (!sync2_q[3] && !sync2_q[2]) shadow_d[7:6] = sync2_q[5:4];
          else                            shadow_d[7:4] = {2'b11, sync2_q[5:4]};
        end
        8'd5: if (sync2_q[3:0] == 4'h0) six_d = 1'b1;
        8'd6: if (six_q) shadow_d[11:8] = sync2_q[3:0];
        8'd7: begin
          joy_d     = six_q ? shadow_q : {4'hF, shadow_q[7:0]};
          six_out_d = six_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync1_q   <= 6'h3F;
      sync2_q   <= 6'h3F;
      shadow_q  <= 12'hFFF;
      six_q     <= 1'b0;
      joy_q     <= 12'hFFF;
      six_out_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      shadow_q  <= shadow_d;
      six_q     <= six_d;
      joy_q     <= joy_d;
      six_out_q <= six_out_d;
    end
  end

  assign joy_o = joy_q;
  assign six_o = six_out_q;
endmodule

module sega_joy_reader #(
  parameter int TICK_DIV = 1536
) (
  input  logic               clk_i,
  input  logic               res_n_i,
  sega_joy_reader_if.slave   bus
);
  localparam int NUM_PORTS = 2;
  localparam int DIV_W     = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       step_q, step_d;
  logic             p7_q, p7_d;
  logic             frame_q, frame_d;
  logic             strobe;

  logic [NUM_PORTS-1:0][5:0]  pins;
  logic [NUM_PORTS-1:0][11:0] joy;
  logic [NUM_PORTS-1:0]       six;

  always_comb begin
    strobe  = (div_q == DIV_W'(TICK_DIV - 1));
    div_d   = strobe ? '0 : div_q + 1'b1;
    step_d  = strobe ? step_q + 8'd1 : step_q;
    p7_d    = p7_q;
    frame_d = strobe && (step_q == 8'd7);
    // Steps 0..7 toggle p7 low/high; the long idle high lets 6-button pads time out
    if (strobe) p7_d = (step_q < 8'd8) ? step_q[0] : 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      div_q   <= '0;
      step_q  <= 8'd0;
      p7_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      step_q  <= step_d;
      p7_q    <= p7_d;
      frame_q <= frame_d;
    end
  end

  assign pins[0] = bus.joy1_pins_i;
  assign pins[1] = bus.joy2_pins_i;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sega_joy_port u_port (
      .clk_i     (clk_i),
      .res_n_i   (res_n_i),
      .pins_i    (pins[g]),
      .step_en_i (strobe),
      .step_i    (step_q),
      .joy_o     (joy[g]),
      .six_o     (six[g])
    );
  end

  assign bus.p7_o    = p7_q;
  assign bus.frame_o = frame_q;
  assign bus.joy1_o  = joy[0];
  assign bus.joy2_o  = joy[1];
  assign bus.six1_o  = six[0];
  assign bus.six2_o  = six[1];
endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench: behavioural pad models (none / SMS / 3-button / 6-button)
// on both ports, checked against hand-computed button words.
module tb_sega_joy_reader;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic res_n;
  int   n_vec = 0;
  int   n_err = 0;

  sega_joy_reader_if jif ();

  sega_joy_reader #(.TICK_DIV(TD)) dut (
    .clk_i   (clk),
    .res_n_i (res_n),
    .bus     (jif)
  );

  always #5 clk = ~clk;

  // pad kind: 0 none, 1 Master System, 2 3-button, 3 6-button
  int          ty1 = 0, ty2 = 0;
  logic [11:0] btn1 = 12'hFFF, btn2 = 12'hFFF;
  logic [2:0]  pad_cnt = 3'd0;
  logic        p7_prev = 1'b1;
  int          hi_cnt = 0;

  // 6-button pad select-low counter, cleared after a long p7-high idle
  always @(posedge clk) begin
    p7_prev <= jif.p7_o;
    if (p7_prev && !jif.p7_o) pad_cnt <= (pad_cnt == 3'd7) ? 3'd7 : pad_cnt + 3'd1;
    else if (hi_cnt > 24)     pad_cnt <= 3'd0;
    if (jif.p7_o) hi_cnt <= hi_cnt + 1;
    else          hi_cnt <= 0;
  end

  function automatic logic [5:0] pad_pins(input int ty, input logic [11:0] b,
                                          input logic p7, input logic [2:0] c);
    logic [5:0] hi_w, lo_w;
    hi_w = {b[5], b[4], b[3:0]};
    lo_w = {b[7], b[6], 2'b00, b[1:0]};
    case (ty)
      1:       return hi_w;
      2:       return p7 ? hi_w : lo_w;
      3: begin
        if (p7) return (c == 3'd3) ? {b[5], b[4], b[11:8]} : hi_w;
        if (c == 3'd3) return {b[7], b[6], 4'h0};
        if (c >= 3'd4) return {b[7], b[6], 4'hF};
        return lo_w;
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign jif.joy1_pins_i = pad_pins(ty1, btn1, jif.p7_o, pad_cnt);
  assign jif.joy2_pins_i = pad_pins(ty2, btn2, jif.p7_o, pad_cnt);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!jif.frame_o && cyc < 3000);
    if (!jif.frame_o) chk("frame_timeout", 32'(jif.frame_o), 32'd1);
  endtask

  task automatic wait_frames2();
    int c;
    wait_frame(c);
    wait_frame(c);
  endtask

  initial begin
    int cyc;
    res_n = 1'b1;
    #2 res_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p7",    32'(jif.p7_o),    32'd1);
    chk("rst_joy1",  32'(jif.joy1_o),  32'hFFF);
    chk("rst_joy2",  32'(jif.joy2_o),  32'hFFF);
    chk("rst_six1",  32'(jif.six1_o),  32'd0);
    chk("rst_six2",  32'(jif.six2_o),  32'd0);
    chk("rst_frame", 32'(jif.frame_o), 32'd0);

    // p7 after each of the first ten strobes, and the first frame pulse
    @(negedge clk) res_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      repeat (TD) @(negedge clk);
      chk($sformatf("p7_step%0d", k), 32'(jif.p7_o), (k < 8) ? 32'(k % 2) : 32'd1);
      chk($sformatf("frame_step%0d", k), 32'(jif.frame_o), (k == 7) ? 32'd1 : 32'd0);
    end

    // no pad on either port
    wait_frame(cyc);
    wait_frame(cyc);
    chk("frame_period", 32'(cyc), 32'(256 * TD));
    chk("nopad_joy1", 32'(jif.joy1_o), 32'hFFF);
    chk("nopad_six1", 32'(jif.six1_o), 32'd0);
    chk("nopad_joy2", 32'(jif.joy2_o), 32'hFFF);

    // 3-button Start+Right on port 1, SMS button 2 on port 2
    ty1 = 2; btn1 = 12'hF77;
    ty2 = 1; btn2 = 12'hFDF;
    wait_frames2();
    chk("md3_joy1",   32'(jif.joy1_o),      32'hF77);
    chk("md3_six1",   32'(jif.six1_o),      32'd0);
    chk("sms_joy2",   32'(jif.joy2_o),      32'hFDF);
    chk("sms_sa",     32'(jif.joy2_o[7:6]), 32'd3);
    chk("sms_six2",   32'(jif.six2_o),      32'd0);

    // 6-button X+Up on port 1, 3-button B on port 2
    ty1 = 3; btn1 = 12'hBFE;
    ty2 = 2; btn2 = 12'hFEF;
    wait_frames2();
    chk("md6_joy1", 32'(jif.joy1_o), 32'hBFE);
    chk("md6_six1", 32'(jif.six1_o), 32'd1);
    chk("ind_joy2", 32'(jif.joy2_o), 32'hFEF);
    chk("ind_six2", 32'(jif.six2_o), 32'd0);

    btn1 = 12'h67F;
    wait_frames2();
    chk("md6_mzs_joy1", 32'(jif.joy1_o), 32'h67F);

    btn1 = 12'hFFF;
    wait_frames2();
    chk("md6_rel_joy1", 32'(jif.joy1_o), 32'hFFF);
    chk("md6_rel_six1", 32'(jif.six1_o), 32'd1);

    // reset in the middle of step 4 of a frame
    btn1 = 12'hBFE;
    wait_frames2();
    chk("pre_rst_joy1", 32'(jif.joy1_o), 32'hBFE);
    repeat (252 * TD) @(posedge clk);
    #3 res_n = 1'b0;
    #1;
    chk("mid_rst_p7",    32'(jif.p7_o),    32'd1);
    chk("mid_rst_joy1",  32'(jif.joy1_o),  32'hFFF);
    chk("mid_rst_six1",  32'(jif.six1_o),  32'd0);
    chk("mid_rst_frame", 32'(jif.frame_o), 32'd0);
    repeat (30) @(negedge clk);
    res_n = 1'b1;
    wait_frame(cyc);
    chk("post_rst_latency", 32'(cyc), 32'(8 * TD));
    chk("post_rst_joy1", 32'(jif.joy1_o), 32'hBFE);
    chk("post_rst_six1", 32'(jif.six1_o), 32'd1);

    // unplug port 1; port 2 unaffected
    ty1 = 0;
    wait_frames2();
    chk("unplug_joy1", 32'(jif.joy1_o), 32'hFFF);
    chk("unplug_six1", 32'(jif.six1_o), 32'd0);
    chk("unplug_joy2", 32'(jif.joy2_o), 32'hFEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
